// File: rtl/uart_cmd_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared types and default constants for the UART command
//               loader (receiver state encoding, frame/baud defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    localparam int CMD_BYTES_DEF    = 7;
    localparam int CLKS_PER_BIT_DEF = 104;

    // Receiver state encoding; PARITY is only reachable in the 8E1 build.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_loader_if
// Description : Command-RAM write port bundle (strobe, address, data).
//               master = loader side, slave = RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_loader_if #(
    parameter int ADDR_W = 12
);
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_out;

    modport master (output ram_we, output ram_addr, output ram_out);
    modport slave  (input  ram_we, input  ram_addr, input  ram_out);
endinterface
`default_nettype wire

// File: rtl/uart_cmd_loader_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver: rx synchronizer, receiver FSM, baud and bit
//               counters, LSB-first shift register. Emits a one-cycle
//               byte_vld with the received byte, and a frm_err_pulse when a
//               stop bit is sampled low. Build macro UART_PARITY_EN switches
//               to 8E1 and adds par_err_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       rx,
    output logic            byte_vld,
    output logic [7:0]      data,
    output logic            busy,
`ifdef UART_PARITY_EN
    output logic            par_err_pulse,
`endif
    output logic            frm_err_pulse
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    logic [1:0]         r_sync;
    logic               w_rxs;
    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [c_CNT_W-1:0] r_baud;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_brk;
    logic               w_full;
    logic               w_half;
`ifdef UART_PARITY_EN
    logic               r_par_bad;
`endif

    assign w_rxs  = r_sync[1];
    assign w_full = (r_baud == c_FULL_M1);
    assign w_half = (r_baud == c_HALF_M1);
    assign data   = r_shift;
    assign busy   = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode and single-cycle event outputs.
    always_comb begin
        w_state_nxt   = r_state;
        byte_vld      = 1'b0;
        frm_err_pulse = 1'b0;
`ifdef UART_PARITY_EN
        par_err_pulse = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rxs) w_state_nxt = START;
            end
            START: begin
                // Mid-start-bit check: a high line here was only a glitch.
                if (w_half) w_state_nxt = w_rxs ? IDLE : DATA;
            end
            DATA: begin
                if (w_full && (r_bit_cnt == 3'd7)) begin
`ifdef UART_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (w_full) begin
                    w_state_nxt   = STOP;
                    par_err_pulse = ^{r_shift, w_rxs};
                end
            end
`endif
            STOP: begin
                if (r_brk) begin
                    // Line held low after a bad stop bit: wait for idle level.
                    if (w_rxs) w_state_nxt = IDLE;
                end else if (w_full) begin
                    if (w_rxs) begin
                        w_state_nxt = IDLE;
`ifdef UART_PARITY_EN
                        byte_vld    = !r_par_bad;
`else
                        byte_vld    = 1'b1;
`endif
                    end else begin
                        frm_err_pulse = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Synchronizer, baud/bit counters and data shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_baud    <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_brk     <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_sync <= {r_sync[0], rx};
            case (r_state)
                IDLE: begin
                    r_baud    <= '0;
                    r_bit_cnt <= 3'd0;
                    r_brk     <= 1'b0;
`ifdef UART_PARITY_EN
                    r_par_bad <= 1'b0;
`endif
                end
                START: begin
                    r_baud <= w_half ? '0 : r_baud + c_ONE;
                end
                DATA: begin
                    if (w_full) begin
                        r_baud    <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else begin
                        r_baud <= r_baud + c_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (w_full) begin
                        r_baud    <= '0;
                        r_par_bad <= ^{r_shift, w_rxs};
                    end else begin
                        r_baud <= r_baud + c_ONE;
                    end
                end
`endif
                STOP: begin
                    if (!r_brk) begin
                        if (w_full) r_brk  <= !w_rxs;
                        else        r_baud <= r_baud + c_ONE;
                    end
                end
                default: r_baud <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_loader
// Description : Loads CMD_BYTES UART bytes sequentially into the command RAM
//               write port and raises ready when the frame is complete.
//               clr discards the frame and rearms. Build macro
//               UART_PARITY_EN selects 8E1 framing and adds par_err.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_loader
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int CMD_BYTES    = CMD_BYTES_DEF,
    parameter int ADDR_W       = 12
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          rx,
    input  wire logic          clr,
    uart_cmd_loader_if.master  ram,
    output logic               ready,
    output logic               busy,
    output logic               frm_err,
`ifdef UART_PARITY_EN
    output logic               par_err,
`endif
    output logic               ovr_err
);

    localparam logic [ADDR_W-1:0] c_FRAME_LEN = ADDR_W'(CMD_BYTES);
    localparam logic [ADDR_W-1:0] c_PTR_ONE   = ADDR_W'(1);

    logic              w_byte_vld;
    logic [7:0]        w_byte;
    logic              w_frm_err_pulse;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [7:0]        r_ram_out;
    logic              r_ready;
    logic              r_frm_err;
    logic              r_ovr_err;
`ifdef UART_PARITY_EN
    logic              w_par_err_pulse;
    logic              r_par_err;
    assign par_err = r_par_err;
`endif

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .byte_vld      (w_byte_vld),
        .data          (w_byte),
        .busy          (busy),
`ifdef UART_PARITY_EN
        .par_err_pulse (w_par_err_pulse),
`endif
        .frm_err_pulse (w_frm_err_pulse)
    );

    assign ram.ram_we   = r_ram_we;
    assign ram.ram_addr = r_ram_addr;
    assign ram.ram_out  = r_ram_out;
    assign ready        = r_ready;
    assign frm_err      = r_frm_err;
    assign ovr_err      = r_ovr_err;

    // Frame loader: RAM write port, write pointer, ready and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_out  <= 8'd0;
            r_ready    <= 1'b0;
            r_frm_err  <= 1'b0;
            r_ovr_err  <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_err  <= 1'b0;
`endif
        end else begin
            r_ram_we <= 1'b0;
            if (clr) begin
                // clr wins over a coincident byte: it is dropped silently.
                r_wr_ptr  <= '0;
                r_ready   <= 1'b0;
                r_frm_err <= 1'b0;
                r_ovr_err <= 1'b0;
`ifdef UART_PARITY_EN
                r_par_err <= 1'b0;
`endif
            end else begin
                // Pointer reaches the frame length the cycle the last strobe
                // is visible, so ready follows one cycle after that strobe.
                if (r_wr_ptr == c_FRAME_LEN) r_ready <= 1'b1;
                if (w_byte_vld) begin
                    if (!r_ready) begin
                        r_ram_we   <= 1'b1;
                        r_ram_addr <= r_wr_ptr;
                        r_ram_out  <= w_byte;
                        r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
                    end else begin
                        r_ovr_err <= 1'b1;
                    end
                end
                if (w_frm_err_pulse) r_frm_err <= 1'b1;
`ifdef UART_PARITY_EN
                if (w_par_err_pulse) r_par_err <= 1'b1;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_loader
// Description : Self-checking bench for uart_cmd_loader: scoreboard of
//               expected RAM writes, flag and timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_loader;

    localparam int CPB = 16;
    localparam int NB  = 7;
    localparam int AW  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic clr = 1'b0;
    logic ready, busy, frm_err, ovr_err;
`ifdef UART_PARITY_EN
    logic par_err;
`endif

    uart_cmd_loader_if #(.ADDR_W(AW)) ram_if ();

    uart_cmd_loader #(
        .CLKS_PER_BIT (CPB),
        .CMD_BYTES    (NB),
        .ADDR_W       (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .clr     (clr),
        .ram     (ram_if),
        .ready   (ready),
        .busy    (busy),
        .frm_err (frm_err),
`ifdef UART_PARITY_EN
        .par_err (par_err),
`endif
        .ovr_err (ovr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard of expected writes {addr, data}, plus a tiny loader model.
    logic [AW+7:0] sb[$];
    int m_ptr   = 0;
    bit m_ready = 1'b0;

    task automatic expect_byte(input logic [7:0] d);
        if (!m_ready) begin
            sb.push_back({AW'(m_ptr), d});
            m_ptr++;
            if (m_ptr == NB) m_ready = 1'b1;
        end
    endtask

    task automatic model_clear();
        m_ptr   = 0;
        m_ready = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on every write strobe and checks
    // that ready rises exactly one cycle after the most recent strobe.
    int cyc = 0;
    int n_writes = 0;
    int last_we_cyc = -100;
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        logic [AW+7:0] e;
        cyc++;
        if (ram_if.ram_we) begin
            n_writes++;
            last_we_cyc = cyc;
            check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("wr_addr", 32'(ram_if.ram_addr), 32'(e[AW+7:8]));
                check_eq("wr_data", 32'(ram_if.ram_out), 32'(e[7:0]));
            end
        end
        if (ready && !prev_ready) check_eq("ready_latency", 32'(cyc - last_we_cyc), 32'd1);
        prev_ready = ready;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
`ifdef UART_PARITY_EN
        rx = ^d;
        tick(CPB);
`endif
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic send_rec(input logic [7:0] d);
        expect_byte(d);
        send_byte(d, 1'b1);
        tick(4);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        model_clear();
        tick(2);
    endtask

    logic [7:0] frame [NB] = '{8'h00, 8'h01, 8'h02, 8'hA5, 8'h5A, 8'hFF, 8'h80};
    int w0;
    bit found;

    initial begin
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_we",    32'(ram_if.ram_we),   32'd0);
        check_eq("rst_addr",  32'(ram_if.ram_addr), 32'd0);
        check_eq("rst_data",  32'(ram_if.ram_out),  32'd0);
        check_eq("rst_ready", 32'(ready),   32'd0);
        check_eq("rst_busy",  32'(busy),    32'd0);
        check_eq("rst_frm",   32'(frm_err), 32'd0);
        check_eq("rst_ovr",   32'(ovr_err), 32'd0);
`ifdef UART_PARITY_EN
        check_eq("rst_par",   32'(par_err), 32'd0);
`endif

        // Basic frame.
        for (int i = 0; i < NB; i++) send_rec(frame[i]);
        @(negedge clk);
        check_eq("basic_ready",  32'(ready), 32'd1);
        check_eq("basic_writes", 32'(n_writes), 32'(NB));

        // Overrun, then clear and reload.
        w0 = n_writes;
        send_rec(8'h33);
        @(negedge clk);
        check_eq("ovr_flag",   32'(ovr_err), 32'd1);
        check_eq("ovr_nowr",   32'(n_writes), 32'(w0));
        check_eq("ovr_ready",  32'(ready), 32'd1);
        pulse_clr();
        @(negedge clk);
        check_eq("clr_ready", 32'(ready), 32'd0);
        check_eq("clr_ovr",   32'(ovr_err), 32'd0);
        for (int i = 0; i < NB; i++) send_rec(frame[i]);
        @(negedge clk);
        check_eq("reload_ready",  32'(ready), 32'd1);
        check_eq("reload_ovr",    32'(ovr_err), 32'd0);
        check_eq("reload_writes", 32'(n_writes), 32'(w0 + NB));

        // Glitch rejection.
        pulse_clr();
        w0 = n_writes;
        rx = 1'b0;
        tick(5);
        @(negedge clk);
        check_eq("glitch_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        tick(20);
        @(negedge clk);
        check_eq("glitch_busy_lo", 32'(busy), 32'd0);
        check_eq("glitch_frm",     32'(frm_err), 32'd0);
        check_eq("glitch_ovr",     32'(ovr_err), 32'd0);
        check_eq("glitch_nowr",    32'(n_writes), 32'(w0));

        // Framing error; next good byte lands at the same address.
        send_byte(8'h3C, 1'b0);
        tick(4);
        @(negedge clk);
        check_eq("frm_flag", 32'(frm_err), 32'd1);
        check_eq("frm_nowr", 32'(n_writes), 32'(w0));
        check_eq("frm_idle", 32'(busy), 32'd0);
        send_rec(8'h11);
        @(negedge clk);
        check_eq("frm_next_wr", 32'(n_writes), 32'(w0 + 1));
        check_eq("frm_sticky",  32'(frm_err), 32'd1);

        // clr coinciding with byte_vld of the third byte.
        pulse_clr();
        send_rec(8'h21);
        send_rec(8'h22);
        w0 = n_writes;
        found = 1'b0;
        fork
            send_byte(8'h23, 1'b1);
            begin
                for (int i = 0; i < 400 && !found; i++) begin
                    @(negedge clk);
                    if (dut.w_byte_vld) begin
                        found = 1'b1;
                        clr = 1'b1;
                        @(posedge clk);
                        #1 clr = 1'b0;
                    end
                end
            end
        join
        model_clear();
        tick(4);
        @(negedge clk);
        check_eq("coll_seen",  32'(found), 32'd1);
        check_eq("coll_nowr",  32'(n_writes), 32'(w0));
        check_eq("coll_ready", 32'(ready), 32'd0);
        check_eq("coll_ovr",   32'(ovr_err), 32'd0);
        send_rec(8'h44);

        // Reset in the middle of data bit 4.
        send_rec(8'h01);
        send_rec(8'h02);
        check_eq("pre_rst_sb", 32'(sb.size()), 32'd0);
        fork
            send_byte(8'hF5, 1'b1);
            begin
                tick(CPB + 4 * CPB + CPB / 2);
                check_eq("mid_busy", 32'(busy), 32'd1);
                rst = 1'b1;
                tick(1);
                @(negedge clk);
                check_eq("mrst_we",    32'(ram_if.ram_we),   32'd0);
                check_eq("mrst_addr",  32'(ram_if.ram_addr), 32'd0);
                check_eq("mrst_data",  32'(ram_if.ram_out),  32'd0);
                check_eq("mrst_busy",  32'(busy),    32'd0);
                check_eq("mrst_ready", 32'(ready),   32'd0);
                check_eq("mrst_frm",   32'(frm_err), 32'd0);
                check_eq("mrst_ovr",   32'(ovr_err), 32'd0);
                rst = 1'b0;
            end
        join
        model_clear();
        tick(4);
        w0 = n_writes;
        for (int i = 0; i < NB; i++) send_rec(frame[NB - 1 - i]);
        @(negedge clk);
        check_eq("post_rst_ready",  32'(ready), 32'd1);
        check_eq("post_rst_writes", 32'(n_writes), 32'(w0 + NB));
        check_eq("sb_drained",      32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
